// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator-sharing arbiter: state encoding,
// datapath width, comparator result bundle and the signed-ordering helper.
package cmp_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Result bundle in the order {a_high, b_high, equal}.
    typedef struct packed {
        logic a_high;
        logic b_high;
        logic equal;
    } cmp_res_t;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    function automatic logic [DATA_W-1:0] signed_bias(input logic [DATA_W-1:0] v);
        return {~v[DATA_W-1], v[DATA_W-2:0]};
    endfunction

endpackage

// File: rtl/Comparator8Bit.sv
// Plain 8-bit unsigned magnitude comparator: exactly one output is high.
module Comparator8Bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       a_high,
    output logic       b_high,
    output logic       equal
);

    assign a_high = (a > b);
    assign b_high = (b > a);
    assign equal  = (a == b);

endmodule

// File: rtl/cmp_share_arbiter_rr_grant.sv
// Round-robin priority picker: first set request at or after the pointer,
// wrapping modulo NUM_REQ. Produces a one-hot grant plus its encoded index.
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;

    // Scan candidates ptr, ptr+1, ... and keep the first one that is requesting.
    always_comb begin
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        sum_s  = '0;
        cand_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum_s >= (IDX_W+1)'(NUM_REQ)) begin
                sum_s = sum_s - (IDX_W+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDX_W-1:0];
            if (!any && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                idx           = cand_s;
                any           = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Shares a single Comparator8Bit between NUM_REQ requesters using round-robin
// arbitration and valid/ready handshakes; one comparison in flight at a time.
// Optional macro CMP_SIGNED_EN: compare operands as two's complement.
module cmp_share_arbiter
    import cmp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_a_high,
    output logic                      rsp_b_high,
    output logic                      rsp_equal
);

    state_t             state_r;
    state_t             state_s;
    logic [ID_W-1:0]    ptr_r;
    logic [ID_W-1:0]    ptr_next_s;
    logic [ID_W-1:0]    id_r;
    logic [DATA_W-1:0]  op_a_r;
    logic [DATA_W-1:0]  op_b_r;
    logic [DATA_W-1:0]  cmp_a_s;
    logic [DATA_W-1:0]  cmp_b_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic               grant_any_s;
    cmp_res_t           cmp_res_s;
    logic               cmp_a_high_s;
    logic               cmp_b_high_s;
    logic               cmp_equal_s;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_rr_grant (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (grant_idx_s),
        .any   (grant_any_s)
    );

`ifdef CMP_SIGNED_EN
    assign cmp_a_s = signed_bias(op_a_r);
    assign cmp_b_s = signed_bias(op_b_r);
`else
    assign cmp_a_s = op_a_r;
    assign cmp_b_s = op_b_r;
`endif

    Comparator8Bit u_cmp (
        .a      (cmp_a_s),
        .b      (cmp_b_s),
        .a_high (cmp_a_high_s),
        .b_high (cmp_b_high_s),
        .equal  (cmp_equal_s)
    );

    assign cmp_res_s = '{a_high: cmp_a_high_s, b_high: cmp_b_high_s, equal: cmp_equal_s};

    // Pointer advances to the slot just after the winner, wrapping at NUM_REQ.
    always_comb begin
        ptr_next_s = '0;
        if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_idx_s + ID_W'(1);
        end
    end

    // Grants are only offered while idle; the picker output is otherwise masked.
    always_comb begin
        req_ready = '0;
        if (state_r == IDLE) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state logic: accept -> compare -> hold response until consumed.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_any_s) begin
                    state_s = COMPARE;
                end else begin
                    state_s = IDLE;
                end
            end
            COMPARE: state_s = RESPOND;
            RESPOND: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESPOND;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, pointer update and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r      <= '0;
            id_r       <= '0;
            op_a_r     <= '0;
            op_b_r     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_a_high <= 1'b0;
            rsp_b_high <= 1'b0;
            rsp_equal  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        op_a_r <= req_a[grant_idx_s*DATA_W +: DATA_W];
                        op_b_r <= req_b[grant_idx_s*DATA_W +: DATA_W];
                        id_r   <= grant_idx_s;
                        ptr_r  <= ptr_next_s;
                    end else begin
                        ptr_r  <= ptr_r;
                    end
                end
                COMPARE: begin
                    rsp_valid  <= 1'b1;
                    rsp_id     <= id_r;
                    rsp_a_high <= cmp_res_s.a_high;
                    rsp_b_high <= cmp_res_s.b_high;
                    rsp_equal  <= cmp_res_s.equal;
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end else begin
                        rsp_valid <= 1'b1;
                    end
                end
                default: rsp_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Scoreboard bench for cmp_share_arbiter: expected results are queued when a
// grant is observed and compared while the response is presented.
module tb_cmp_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [8*NUM_REQ-1:0]  req_a;
    logic [8*NUM_REQ-1:0]  req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_a_high;
    logic                  rsp_b_high;
    logic                  rsp_equal;

    cmp_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_a_high (rsp_a_high),
        .rsp_b_high (rsp_b_high),
        .rsp_equal  (rsp_equal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [2:0]      res;
    } exp_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    exp_t       sb_q[$];
    int         grant_log[$];
    logic [7:0] op_a[NUM_REQ];
    logic [7:0] op_b[NUM_REQ];
    int         pend_cnt[NUM_REQ];
    int         m_state  = 0;
    int         m_ptr    = 0;
    int         hold_cnt = 0;
    int         stall_cycles = 0;
    bit         rand_bp  = 1'b0;
    logic [NUM_REQ-1:0] last_ready;
    logic       last_rsp_valid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_cmp(input logic [7:0] a, input logic [7:0] b);
`ifdef CMP_SIGNED_EN
        if ($signed(a) > $signed(b)) return 3'b100;
        else if ($signed(a) < $signed(b)) return 3'b010;
        else return 3'b001;
`else
        if (a > b) return 3'b100;
        else if (a < b) return 3'b010;
        else return 3'b001;
`endif
    endfunction

    task automatic post(input int i, input logic [7:0] a, input logic [7:0] b, input int cnt);
        op_a[i]     = a;
        op_b[i]     = b;
        pend_cnt[i] = cnt;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]     = (pend_cnt[i] > 0);
            req_a[i*8 +: 8]  = op_a[i];
            req_b[i*8 +: 8]  = op_b[i];
        end
        rsp_ready = (hold_cnt == 0);
    endtask

    // One clock: drive, sample away from the edge, then advance the model.
    task automatic tick();
        int k;
        logic [NUM_REQ-1:0] exp_grant;
        @(negedge clk);
        drive_inputs();
        #1;
        k = -1;
        exp_grant = '0;
        if (m_state == 0) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                int c;
                c = (m_ptr + j) % NUM_REQ;
                if (k < 0 && req_valid[c]) k = c;
            end
        end
        if (k >= 0) exp_grant[k] = 1'b1;
        last_ready     = req_ready;
        last_rsp_valid = rsp_valid;
        check_eq("req_ready", req_ready, exp_grant);
        check_eq("rsp_valid", rsp_valid, (m_state == 2));
        if (rsp_valid) begin
            if (!rsp_ready) stall_cycles++;
            check_eq("one_hot", $countones({rsp_a_high, rsp_b_high, rsp_equal}), 1);
            if (sb_q.size() > 0) begin
                check_eq("rsp_id", rsp_id, sb_q[0].id);
                check_eq("rsp_flags", {rsp_a_high, rsp_b_high, rsp_equal}, sb_q[0].res);
            end else begin
                check_eq("sb_nonempty", sb_q.size(), 1);
            end
        end
        @(posedge clk);
        if (reset) begin
            m_state = 0;
            m_ptr   = 0;
            sb_q.delete();
        end else begin
            case (m_state)
                0: if (k >= 0) begin
                    sb_q.push_back('{id: ID_W'(k), res: ref_cmp(op_a[k], op_b[k])});
                    grant_log.push_back(k);
                    m_ptr = (k + 1) % NUM_REQ;
                    m_state = 1;
                    pend_cnt[k]--;
                    op_a[k] = 8'($urandom);
                    op_b[k] = 8'($urandom);
                    if (rand_bp) hold_cnt = $urandom_range(0, 2);
                end
                1: m_state = 2;
                default: begin
                    if (rsp_ready) begin
                        void'(sb_q.pop_front());
                        m_state = 0;
                    end else if (hold_cnt > 0) begin
                        hold_cnt--;
                    end
                end
            endcase
        end
    endtask

    task automatic run_idle(input int budget);
        int cyc;
        bit busy;
        cyc = 0;
        busy = 1'b1;
        while (busy && cyc < budget) begin
            tick();
            cyc++;
            busy = (m_state != 0) || (sb_q.size() != 0);
            for (int i = 0; i < NUM_REQ; i++) if (pend_cnt[i] > 0) busy = 1'b1;
        end
        if (busy) check_eq("drain_timeout", cyc, 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < NUM_REQ; i++) pend_cnt[i] = 0;
        hold_cnt = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        grant_log.delete();
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) post(i, 8'h00, 8'h00, 0);
        reset = 1'b1;
        drive_inputs();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_id", rsp_id, 0);
        check_eq("rst_flags", {rsp_a_high, rsp_b_high, rsp_equal}, 0);

        // Single request with explicit latency checks.
        post(0, 8'h50, 8'h30, 1);
        tick();
        check_eq("single_grant", last_ready, 4'b0001);
        tick();
        check_eq("single_lat1", last_rsp_valid, 0);
        tick();
        check_eq("single_lat2", last_rsp_valid, 1);
        check_eq("single_flags", {rsp_a_high, rsp_b_high, rsp_equal}, 3'b100);
        run_idle(50);

        // Fairness: all requesters valid twice each.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) post(i, 8'(i * 16), 8'h20, 2);
        run_idle(200);
        check_eq("fair_count", grant_log.size(), 8);
        for (int j = 0; j < grant_log.size(); j++) check_eq("fair_order", grant_log[j], j % NUM_REQ);

        // Backpressure with an equal result and a second requester waiting.
        do_reset();
        stall_cycles = 0;
        hold_cnt = 5;
        post(0, 8'h22, 8'h22, 1);
        tick();
        post(1, 8'h01, 8'h02, 1);
        run_idle(100);
        check_eq("bp_stall", stall_cycles, 5);
        check_eq("bp_order", grant_log.size() == 2 ? grant_log[1] : -1, 1);

        // Pointer wrap: after granting 0,1,2 the pointer sits at 3.
        do_reset();
        post(0, 8'h10, 8'h11, 1);
        post(1, 8'h12, 8'h11, 1);
        post(2, 8'h13, 8'h13, 1);
        run_idle(100);
        post(0, 8'h05, 8'h06, 1);
        post(2, 8'h07, 8'h06, 1);
        run_idle(100);
        check_eq("wrap_count", grant_log.size(), 5);
        if (grant_log.size() == 5) begin
            check_eq("wrap_first", grant_log[3], 0);
            check_eq("wrap_second", grant_log[4], 2);
        end

        // Reset while a comparison is in flight.
        do_reset();
        post(1, 8'h40, 8'h41, 1);
        post(2, 8'h40, 8'h41, 1);
        tick();
        tick();
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) pend_cnt[i] = 0;
        tick();
        reset = 1'b0;
        grant_log.delete();
        tick();
        check_eq("rstc_rsp_valid", last_rsp_valid, 0);
        check_eq("rstc_req_ready", last_ready, 0);
        tick();
        check_eq("rstc_rsp_valid2", last_rsp_valid, 0);
        for (int i = 0; i < NUM_REQ; i++) post(i, 8'h33, 8'h34, 1);
        run_idle(100);
        check_eq("rstc_ptr0", grant_log.size() > 0 ? grant_log[0] : -1, 0);

        // Sign-sensitive pattern.
        post(3, 8'hFF, 8'h01, 1);
        post(1, 8'h80, 8'h7F, 1);
        run_idle(100);

        // Random traffic with random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) post(i, 8'($urandom), 8'($urandom), int'($urandom_range(3, 8)));
        run_idle(2000);
        rand_bp = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_share_arbiter.md
Name: cmp_share_arbiter

Overview:
- Shares one 8-bit magnitude comparator datapath (Comparator8Bit: a_high/b_high/equal) between NUM_REQ requesters.
- Round-robin arbitration with valid/ready handshakes on both sides; one comparison in flight.
- Sits between client blocks (sorters, threshold checkers) and the single comparator instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of rsp_id; must satisfy 2^ID_W >= NUM_REQ

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  8*NUM_REQ  operand A; requester i at bits [8i+7:8i]
- req_b  in  8*NUM_REQ  operand B, same packing
- req_ready  out  NUM_REQ  one-hot grant/accept strobe
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  ID_W  index of requester owning the result
- rsp_a_high  out  1  A > B
- rsp_b_high  out  1  B > A
- rsp_equal  out  1  A == B

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=IDLE, rr pointer=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_a_high=0, rsp_b_high=0, rsp_equal=0, operand regs=0.
- FSM states: IDLE, COMPARE, RESPOND.
- IDLE:
  - Search req_valid starting at rr pointer, wrapping modulo NUM_REQ.
  - First set bit k gets req_ready[k]=1, combinational from req_valid and pointer; all other bits are 0.
  - On that edge: latch req_a/req_b slice k and id k; pointer <= (k+1) mod NUM_REQ; go to COMPARE.
  - No valid requests: stay in IDLE, req_ready=0, pointer unchanged.
- COMPARE:
  - Latched operands drive the comparator.
  - Its three outputs are registered into rsp_* along with rsp_id.
  - rsp_valid <= 1; go to RESPOND.
- RESPOND:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
- req_ready is 0 in COMPARE and RESPOND.
- Latency: accept edge to rsp_valid high is 2 clk edges. Best-case throughput is one result per 3 cycles.
- Exactly one of rsp_a_high/rsp_b_high/rsp_equal is 1 whenever rsp_valid=1.
- Requester protocol:
  - Requester holds req_valid and operands until it sees req_ready.
  - Deasserting req_valid before grant is legal; the arbiter ignores that requester.
- Simultaneous requests: round-robin fairness. With all requesters valid, grant order from reset is 0,1,2,3,0,...
- A single requester re-requesting immediately is granted on its next IDLE cycle.
- Reset mid-operation (any state): the in-flight comparison is discarded, no response is issued, and all reset values apply on the next edge.
- ID_W wider than needed: rsp_id zero-extended.

Optional Feature:
- Macro: CMP_SIGNED_EN.
- Defined: operands are treated as two's complement. Bit 7 of both latched operands is inverted before the comparator input, so the unsigned datapath gives a signed ordering. rsp_* report signed relations.
- Undefined: unsigned comparison, no inversion logic present.
- Timing and handshakes are identical either way.

Decomposition:
- Shared package cmp_pkg holds:
  - state encoding constants (IDLE=2'd0, COMPARE=2'd1, RESPOND=2'd2)
  - DATA_W=8
  - result bundle field order {a_high,b_high,equal}
- Natural sub-module: rr_grant (NUM_REQ-wide round-robin priority picker: inputs req vector and pointer; outputs one-hot grant and encoded index).
- Comparator8Bit is instantiated once, unmodified.

Test Plan:
- Single request: after reset, req_valid=0001, a=8'h50, b=8'h30 → req_ready=0001 same cycle; 2 edges later rsp_valid=1, id=0, a_high=1, b_high=0, equal=0.
- Fairness: all four valid continuously with rsp_ready=1 → grants 0,1,2,3,0 at 3-cycle spacing; each rsp_id matches grant order.
- Backpressure: rsp_ready=0 for 5 cycles with result a=8'h22, b=8'h22 → rsp_valid and equal=1 held stable 5 cycles, no new req_ready; one cycle after rsp_ready=1, state IDLE.
- Pointer wrap: pointer=3 (after granting 2), req_valid=0101 → grant 0, then 2 on next IDLE.
- Reset in COMPARE: pulse reset → next cycle rsp_valid=0, req_ready=0, pointer=0, no response emitted.
- CMP_SIGNED_EN defined: a=8'hFF (−1), b=8'h01 → b_high=1. Same stimulus without macro → a_high=1.
